// File: rtl/cpu_wb_master.sv
// Bridge from the multi-cycle CPU memory port to a single-beat Wishbone classic master.
// One bus cycle per CPU request, with lane steering, timeout abort and sticky error capture.
module cpu_wb_master #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_signed,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    output logic [3:0]  m_sel_o,
    output logic        m_we_o,
    output logic        m_stb_o,
    output logic        m_cyc_o,
    input  logic        m_ack_i,
    input  logic        err_clr,
    output logic        err_flag,
    output logic [1:0]  err_code,
    output logic [31:0] err_addr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 32'd1);

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    is_misaligned = 1'b0;
            2'd1:    is_misaligned = off[0];
            default: is_misaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    lane_sel = 4'b0001 << off;
            2'd1:    lane_sel = off[1] ? 4'b1100 : 4'b0011;
            default: lane_sel = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_rep(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'd0:    lane_rep = {4{wdata[7:0]}};
            2'd1:    lane_rep = {2{wdata[15:0]}};
            default: lane_rep = wdata;
        endcase
    endfunction

    // Lane is shifted down to bit 0 before extension, so byte/half share one path.
    function automatic logic [31:0] load_align(input logic [1:0] size, input logic sgn,
                                               input logic [1:0] off, input logic [31:0] dat);
        logic [31:0] sh;
        sh = dat >> {off, 3'b000};
        case (size)
            2'd0:    load_align = sgn ? {{24{sh[7]}}, sh[7:0]} : {24'h00_0000, sh[7:0]};
            2'd1:    load_align = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0000, sh[15:0]};
            default: load_align = dat;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        stb_q, stb_d;
    logic        cyc_q, cyc_d;
    logic        eflag_q, eflag_d;
    logic [1:0]  ecode_q, ecode_d;
    logic [31:0] eaddr_q, eaddr_d;
    logic        new_err_s;
    logic [1:0]  new_code_s;
    logic [31:0] new_addr_s;

    // Next-state logic for the request/bus/hold sequencer and error capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        size_d     = size_q;
        sgn_d      = sgn_q;
        rdata_d    = rdata_q;
        ready_d    = ready_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        sel_d      = sel_q;
        we_d       = we_q;
        stb_d      = stb_q;
        cyc_d      = cyc_q;
        new_err_s  = 1'b0;
        new_code_s = 2'b00;
        new_addr_s = 32'h0000_0000;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    if (is_misaligned(cpu_size, cpu_addr[1:0])) begin
                        rdata_d    = ERR_DATA;
                        ready_d    = 1'b1;
                        new_err_s  = 1'b1;
                        new_code_s = 2'b10;
                        new_addr_s = cpu_addr;
                        state_d    = ST_HOLD;
                    end else begin
                        addr_d  = cpu_addr;
                        size_d  = cpu_size;
                        sgn_d   = cpu_signed;
                        adr_d   = {cpu_addr[31:2], 2'b00};
                        sel_d   = lane_sel(cpu_size, cpu_addr[1:0]);
                        dat_d   = lane_rep(cpu_size, cpu_wdata);
                        we_d    = cpu_we;
                        stb_d   = 1'b1;
                        cyc_d   = 1'b1;
                        cnt_d   = 16'd0;
                        state_d = ST_BUS;
                    end
                end else begin
                    ready_d = 1'b0;
                end
            end
            ST_BUS: begin
                // Ack is checked first so a same-cycle ack beats the timeout.
                if (m_ack_i) begin
                    stb_d   = 1'b0;
                    cyc_d   = 1'b0;
                    rdata_d = we_q ? 32'h0000_0000 : load_align(size_q, sgn_q, addr_q[1:0], m_dat_i);
                    ready_d = 1'b1;
                    state_d = ST_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    stb_d      = 1'b0;
                    cyc_d      = 1'b0;
                    rdata_d    = ERR_DATA;
                    ready_d    = 1'b1;
                    new_err_s  = 1'b1;
                    new_code_s = 2'b01;
                    new_addr_s = addr_q;
                    state_d    = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_HOLD: begin
                if (!cpu_req) begin
                    ready_d = 1'b0;
                    cnt_d   = 16'd0;
                    state_d = ST_IDLE;
                end else begin
                    ready_d = 1'b1;
                end
            end
            default: begin
                stb_d   = 1'b0;
                cyc_d   = 1'b0;
                ready_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        if (new_err_s && (!eflag_q || err_clr)) begin
            eflag_d = 1'b1;
            ecode_d = new_code_s;
            eaddr_d = new_addr_s;
        end else if (err_clr) begin
            eflag_d = 1'b0;
            ecode_d = 2'b00;
            eaddr_d = eaddr_q;
        end else begin
            eflag_d = eflag_q;
            ecode_d = ecode_q;
            eaddr_d = eaddr_q;
        end
    end

    // State and registered outputs; async reset drops the bus cycle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            addr_q  <= 32'h0000_0000;
            size_q  <= 2'd0;
            sgn_q   <= 1'b0;
            rdata_q <= 32'h0000_0000;
            ready_q <= 1'b0;
            adr_q   <= 32'h0000_0000;
            dat_q   <= 32'h0000_0000;
            sel_q   <= 4'b0000;
            we_q    <= 1'b0;
            stb_q   <= 1'b0;
            cyc_q   <= 1'b0;
            eflag_q <= 1'b0;
            ecode_q <= 2'b00;
            eaddr_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            stb_q   <= stb_d;
            cyc_q   <= cyc_d;
            eflag_q <= eflag_d;
            ecode_q <= ecode_d;
            eaddr_q <= eaddr_d;
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_ready = ready_q;
    assign m_adr_o   = adr_q;
    assign m_dat_o   = dat_q;
    assign m_sel_o   = sel_q;
    assign m_we_o    = we_q;
    assign m_stb_o   = stb_q;
    assign m_cyc_o   = cyc_q;
    assign err_flag  = eflag_q;
    assign err_code  = ecode_q;
    assign err_addr  = eaddr_q;

endmodule

// File: tb/tb_cpu_wb_master.sv
// Directed self-checking bench for cpu_wb_master (TIMEOUT overridden to 8).
module tb_cpu_wb_master;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [1:0]  cpu_size;
    logic        cpu_signed;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic [31:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic [31:0] m_dat_i;
    logic [3:0]  m_sel_o;
    logic        m_we_o;
    logic        m_stb_o;
    logic        m_cyc_o;
    logic        m_ack_i;
    logic        err_clr;
    logic        err_flag;
    logic [1:0]  err_code;
    logic [31:0] err_addr;

    int n_tests;
    int n_fail;

    logic [31:0] sel_seen, adr_seen, dat_seen, rdata_seen;
    logic        we_seen;
    int          cyc_cnt, lat;

    cpu_wb_master #(.TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_size(cpu_size),
        .cpu_signed(cpu_signed), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_sel_o(m_sel_o),
        .m_we_o(m_we_o), .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o), .m_ack_i(m_ack_i),
        .err_clr(err_clr), .err_flag(err_flag), .err_code(err_code), .err_addr(err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ack_after: number of observed cyc cycles before the slave acks (0 = never).
    task automatic run_xfer(input logic we, input logic [31:0] addr, input logic [1:0] size,
                            input logic sgn, input logic [31:0] wdata, input int ack_after,
                            input logic [31:0] resp, input logic clr_first);
        bit done;
        done       = 1'b0;
        cyc_cnt    = 0;
        lat        = 0;
        cpu_req    = 1'b1;
        cpu_we     = we;
        cpu_addr   = addr;
        cpu_size   = size;
        cpu_signed = sgn;
        cpu_wdata  = wdata;
        err_clr    = clr_first;
        for (int i = 0; i < 50 && !done; i++) begin
            @(posedge clk);
            #1;
            err_clr = 1'b0;
            m_ack_i = 1'b0;
            m_dat_i = 32'h0000_0000;
            lat++;
            if (m_cyc_o) begin
                cyc_cnt++;
                sel_seen = {28'h000_0000, m_sel_o};
                adr_seen = m_adr_o;
                dat_seen = m_dat_o;
                we_seen  = m_we_o;
                if (cyc_cnt == ack_after) begin
                    m_ack_i = 1'b1;
                    m_dat_i = resp;
                end
            end
            if (cpu_ready) done = 1'b1;
        end
        if (!done) check_val("ready_wait", 32'd0, 32'd1);
        rdata_seen = cpu_rdata;
    endtask

    // Ready must stay up with no new bus cycle while req is held, then fall after release.
    task automatic release_req(input string tag);
        repeat (2) @(posedge clk);
        #1;
        check_val({tag, "_ready_held"}, {31'd0, cpu_ready}, 32'd1);
        check_val({tag, "_no_recycle"}, {31'd0, m_cyc_o}, 32'd0);
        check_val({tag, "_rdata_held"}, cpu_rdata, rdata_seen);
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        check_val({tag, "_ready_drop"}, {31'd0, cpu_ready}, 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_size = 2'd0;
        cpu_signed = 1'b0; cpu_wdata = 32'h0; m_dat_i = 32'h0; m_ack_i = 1'b0; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_cyc", {31'd0, m_cyc_o}, 32'd0);
        check_val("rst_ready", {31'd0, cpu_ready}, 32'd0);
        check_val("rst_rdata", cpu_rdata, 32'h0);
        check_val("rst_err", {29'd0, err_flag, err_code}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Word load, ack on second bus cycle.
        run_xfer(1'b0, 32'h0000_0010, 2'd2, 1'b0, 32'h0, 2, 32'h1234_5678, 1'b0);
        check_val("wl_sel", sel_seen, 32'hF);
        check_val("wl_we", {31'd0, we_seen}, 32'd0);
        check_val("wl_adr", adr_seen, 32'h0000_0010);
        check_val("wl_stb_cycles", cyc_cnt, 32'd2);
        check_val("wl_rdata", rdata_seen, 32'h1234_5678);
        release_req("wl");

        run_xfer(1'b0, 32'h0000_0003, 2'd0, 1'b1, 32'h0, 1, 32'h8000_0000, 1'b0);
        check_val("sb_sel", sel_seen, 32'h8);
        check_val("sb_rdata", rdata_seen, 32'hFFFF_FF80);
        release_req("sb");

        run_xfer(1'b0, 32'h0000_0003, 2'd0, 1'b0, 32'h0, 1, 32'h8000_0000, 1'b0);
        check_val("ub_rdata", rdata_seen, 32'h0000_0080);
        release_req("ub");

        run_xfer(1'b0, 32'h0000_0102, 2'd1, 1'b1, 32'h0, 1, 32'h9ABC_0000, 1'b0);
        check_val("sh_sel", sel_seen, 32'hC);
        check_val("sh_rdata", rdata_seen, 32'hFFFF_9ABC);
        release_req("sh");

        run_xfer(1'b1, 32'h0000_0006, 2'd1, 1'b0, 32'h0000_ABCD, 1, 32'h5555_5555, 1'b0);
        check_val("hs_sel", sel_seen, 32'hC);
        check_val("hs_dat", dat_seen, 32'hABCD_ABCD);
        check_val("hs_adr", adr_seen, 32'h0000_0004);
        check_val("hs_we", {31'd0, we_seen}, 32'd1);
        check_val("hs_rdata", rdata_seen, 32'h0);
        release_req("hs");

        run_xfer(1'b1, 32'h0000_0009, 2'd0, 1'b0, 32'h0000_0042, 1, 32'h0, 1'b0);
        check_val("bs_sel", sel_seen, 32'h2);
        check_val("bs_dat", dat_seen, 32'h4242_4242);
        release_req("bs");

        // Timeout: 8 strobe cycles, then error data and code 01.
        run_xfer(1'b0, 32'h0000_0020, 2'd2, 1'b0, 32'h0, 0, 32'h0, 1'b0);
        check_val("to_stb_cycles", cyc_cnt, 32'd8);
        check_val("to_rdata", rdata_seen, 32'hDEAD_BEEF);
        check_val("to_flag", {31'd0, err_flag}, 32'd1);
        check_val("to_code", {30'd0, err_code}, 32'd1);
        check_val("to_addr", err_addr, 32'h0000_0020);
        release_req("to");

        run_xfer(1'b0, 32'h0000_0030, 2'd2, 1'b0, 32'h0, 0, 32'h0, 1'b0);
        check_val("to2_addr_kept", err_addr, 32'h0000_0020);
        check_val("to2_code_kept", {30'd0, err_code}, 32'd1);
        release_req("to2");

        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check_val("clr_flag", {31'd0, err_flag}, 32'd0);
        check_val("clr_code", {30'd0, err_code}, 32'd0);

        // Misaligned word load: no bus cycle, fast ready, code 10.
        run_xfer(1'b0, 32'h0000_0002, 2'd2, 1'b0, 32'h0, 1, 32'h0, 1'b0);
        check_val("ma_no_cyc", cyc_cnt, 32'd0);
        check_val("ma_latency_le2", {31'd0, (lat <= 2)}, 32'd1);
        check_val("ma_rdata", rdata_seen, 32'hDEAD_BEEF);
        check_val("ma_code", {30'd0, err_code}, 32'd2);
        check_val("ma_addr", err_addr, 32'h0000_0002);
        release_req("ma");

        // err_clr coincident with a new misaligned half error: new error is recorded.
        run_xfer(1'b0, 32'h0000_0045, 2'd1, 1'b0, 32'h0, 1, 32'h0, 1'b1);
        check_val("clrnew_flag", {31'd0, err_flag}, 32'd1);
        check_val("clrnew_addr", err_addr, 32'h0000_0045);
        release_req("clrnew");

        // Async reset while a bus cycle is open.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0040; cpu_size = 2'd2;
        @(posedge clk);
        #1;
        check_val("rb_stb_up", {31'd0, m_stb_o}, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rb_stb", {31'd0, m_stb_o}, 32'd0);
        check_val("rb_cyc", {31'd0, m_cyc_o}, 32'd0);
        check_val("rb_ready", {31'd0, cpu_ready}, 32'd0);
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rb_no_resume", {31'd0, m_cyc_o}, 32'd0);

        // Ack on the final timeout cycle: ack wins, no error.
        run_xfer(1'b0, 32'h0000_0050, 2'd2, 1'b0, 32'h0, 8, 32'hCAFE_F00D, 1'b0);
        check_val("at_cycles", cyc_cnt, 32'd8);
        check_val("at_rdata", rdata_seen, 32'hCAFE_F00D);
        check_val("at_no_err", {31'd0, err_flag}, 32'd0);
        release_req("at");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
